axis_arb_out_fifo: RTL and testbench

Synchronous AXI-Stream FIFO that sits directly downstream of the 4-input arbiter/mux and buffers its merged output stream before the egress interface. It absorbs back-pressure so the arbiter can finish granted frames without stalling, and reports occupancy and stored-frame count. An optional store-and-forward mode withholds output until a complete frame (tlast) is buffered.

---
 rtl/axis_arb_out_fifo_if.sv | 23 ++
 rtl/axis_arb_out_fifo.sv | 118 +++++++++++
 tb/tb_axis_arb_out_fifo.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_arb_out_fifo_if.sv
// axis_arb_out_fifo_if
// AXI-Stream bundle used on both sides of axis_arb_out_fifo.
//   tdata  [DATA_WIDTH] payload
//   tvalid              source has a word
//   tlast               end of frame
//   tuser  [USER_WIDTH] sideband
//   tready              sink accepts
// Modports:
//   master - drives the stream (tdata/tvalid/tlast/tuser), receives tready
//   slave  - receives the stream, drives tready
interface axis_arb_out_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_arb_out_fifo.sv
// axis_arb_out_fifo
// AXI-Stream FIFO placed after the 4-input arbiter/mux. It buffers the
// merged stream so the arbiter can finish granted frames under egress
// back-pressure. It also reports stored words and stored complete frames.
//
// Ports:
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   s_axis         slave modport, stream from the arbiter (tready = !full && !rst)
//   m_axis         master modport, first-word-fall-through head of the FIFO;
//                  data fields read as zero whenever tvalid is low
//   status_count   entries stored, 0..2**ADDR_WIDTH (registered)
//   status_frames  tlast entries stored (registered)
//
// Optional feature macro: AXIS_OUT_FIFO_STORE_FWD_EN
//   Defined     - store-and-forward. The head is withheld until a complete
//                 frame is stored, or until the FIFO is full (oversize frame).
//   Not defined - cut-through. The head is presented as soon as it is stored.
module axis_arb_out_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_arb_out_fifo_if.slave    s_axis,
  axis_arb_out_fifo_if.master   m_axis,
  output logic [ADDR_WIDTH:0]   status_count,
  output logic [ADDR_WIDTH:0]   status_frames
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int WORD_W = DATA_WIDTH + USER_WIDTH + 1;

  // Each word is stored as {tlast, tuser, tdata}.
  logic [WORD_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  wr_en;
  logic                  rd_en;
  logic                  out_valid;
  logic [WORD_W-1:0]     head;
  logic [WORD_W-1:0]     wr_word;
  logic [USER_WIDTH-1:0] in_user;

  // The extra pointer MSB tells full apart from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                 (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // tready does not look at the read side. A slot freed by a read this
  // cycle can be written from the next cycle onward.
  assign s_axis.tready = !full && !rst;

  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = out_valid && m_axis.tready;

  assign in_user = (USER_ENABLE != 0) ? s_axis.tuser : USER_WIDTH'(0);
  assign wr_word = {s_axis.tlast, in_user, s_axis.tdata};
  assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];

`ifdef AXIS_OUT_FIFO_STORE_FWD_EN
  // Release the head once a whole frame is stored, or when the FIFO is
  // full. The full case drains an oversize frame and avoids deadlock.
  // Both terms can only drop through a read, so a presented word stays
  // valid until it is accepted.
  assign out_valid = !empty && ((status_frames != '0) || full);
`else
  assign out_valid = !empty;
`endif

  // The outputs are masked to zero while nothing is presented. Entries that
  // remain after a reset are never visible.
  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_axis.tuser  = (out_valid && (USER_ENABLE != 0)) ?
                         head[DATA_WIDTH +: USER_WIDTH] : '0;
  assign m_axis.tlast  = out_valid && head[WORD_W-1];

  // The storage array has no reset. The pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      status_count  <= '0;
      status_frames <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({wr_en, rd_en})
        2'b10:   status_count <= status_count + 1'b1;
        2'b01:   status_count <= status_count - 1'b1;
        default: status_count <= status_count;
      endcase

      case ({wr_en && s_axis.tlast, rd_en && head[WORD_W-1]})
        2'b10:   status_frames <= status_frames + 1'b1;
        2'b01:   status_frames <= status_frames - 1'b1;
        default: status_frames <= status_frames;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_arb_out_fifo.sv
// tb_axis_arb_out_fifo
// Directed testbench for axis_arb_out_fifo with the default parameters
// (DATA_WIDTH=8, USER_WIDTH=1, ADDR_WIDTH=4, depth 16). Each scenario task
// drives its stimulus and compares against hand-computed values. The inputs
// change 1 time unit after each rising edge and the outputs are sampled at
// the same point. Store-and-forward scenarios are compiled only when
// AXIS_OUT_FIFO_STORE_FWD_EN is defined.
module tb_axis_arb_out_fifo;

  logic       clk;
  logic       rst;
  logic [4:0] status_count;
  logic [4:0] status_frames;
  int         checks;
  int         errors;

  axis_arb_out_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) in_if ();
  axis_arb_out_fifo_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) out_if ();

  axis_arb_out_fifo #(
    .DATA_WIDTH (8),
    .USER_ENABLE(1),
    .USER_WIDTH (1),
    .ADDR_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (in_if.slave),
    .m_axis       (out_if.master),
    .status_count (status_count),
    .status_frames(status_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = '0;
    out_if.tready = 1'b0;
    cycle();
    cycle();
    checks++;
    if (in_if.tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tready_in_reset got %b want 0", in_if.tready);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (in_if.tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_tready got %b want 1", in_if.tready);
    end
    checks++;
    if (out_if.tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_tvalid got %b want 0", out_if.tvalid);
    end
    checks++;
    if (status_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_count got %0d want 0", status_count);
    end
    checks++;
    if (status_frames !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_frames got %0d want 0", status_frames);
    end
    checks++;
    if (out_if.tdata !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_tdata got %h want 00", out_if.tdata);
    end
  endtask

`ifndef AXIS_OUT_FIFO_STORE_FWD_EN
  task automatic test_single_frame();
    logic [7:0] words [3];
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    out_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.tvalid = 1'b1;
      in_if.tdata  = words[i];
      in_if.tlast  = (i == 2);
      in_if.tuser  = 1'(i);
      cycle();
      // A word written in the previous cycle is at the head now. The word
      // before it was read at the same edge, so one entry remains.
      checks++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== words[i]) begin
        errors++;
        $display("[TB] FAIL frame_head%0d got v=%b d=%h want v=1 d=%h",
                 i, out_if.tvalid, out_if.tdata, words[i]);
      end
      checks++;
      if (out_if.tlast !== (i == 2) || out_if.tuser !== 1'(i)) begin
        errors++;
        $display("[TB] FAIL frame_side%0d got last=%b user=%b want last=%b user=%b",
                 i, out_if.tlast, out_if.tuser, (i == 2), 1'(i));
      end
      checks++;
      if (status_count !== 5'd1) begin
        errors++;
        $display("[TB] FAIL frame_count%0d got %0d want 1", i, status_count);
      end
    end
    checks++;
    if (status_frames !== 5'd1) begin
      errors++;
      $display("[TB] FAIL frame_frames_stored got %0d want 1", status_frames);
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    cycle();
    checks++;
    if (out_if.tvalid !== 1'b0 || status_count !== 5'd0 || status_frames !== 5'd0) begin
      errors++;
      $display("[TB] FAIL frame_drained got v=%b cnt=%0d frm=%0d want v=0 cnt=0 frm=0",
               out_if.tvalid, status_count, status_frames);
    end
  endtask

  task automatic test_fill();
    out_if.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (in_if.tready !== 1'(i < 16)) begin
        errors++;
        $display("[TB] FAIL fill_tready%0d got %b want %b", i, in_if.tready, 1'(i < 16));
      end
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'h40 + 8'(i);
      cycle();
    end
    in_if.tvalid = 1'b0;
    checks++;
    if (status_count !== 5'd16 || in_if.tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full got cnt=%0d rdy=%b want cnt=16 rdy=0",
               status_count, in_if.tready);
    end
    checks++;
    if (out_if.tdata !== 8'h40) begin
      errors++;
      $display("[TB] FAIL fill_head got %h want 40", out_if.tdata);
    end
    out_if.tready = 1'b1;
    cycle();
    checks++;
    if (in_if.tready !== 1'b1 || status_count !== 5'd15) begin
      errors++;
      $display("[TB] FAIL fill_one_read got rdy=%b cnt=%0d want rdy=1 cnt=15",
               in_if.tready, status_count);
    end
    // Word 0x50 was offered while the FIFO was full, so it must not appear.
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h40 + 8'(k)) begin
        errors++;
        $display("[TB] FAIL fill_drain%0d got v=%b d=%h want v=1 d=%h",
                 k, out_if.tvalid, out_if.tdata, 8'h40 + 8'(k));
      end
      cycle();
    end
    checks++;
    if (out_if.tvalid !== 1'b0 || status_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL fill_empty got v=%b cnt=%0d want v=0 cnt=0",
               out_if.tvalid, status_count);
    end
  endtask

  task automatic test_back_to_back();
    out_if.tready = 1'b0;
    in_if.tlast   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'(i);
      cycle();
    end
    out_if.tready = 1'b1;
    for (int j = 0; j < 40; j++) begin
      checks++;
      if (status_count !== 5'd8 || out_if.tdata !== 8'(j)) begin
        errors++;
        $display("[TB] FAIL stream%0d got cnt=%0d d=%h want cnt=8 d=%h",
                 j, status_count, out_if.tdata, 8'(j));
      end
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'(8 + j);
      cycle();
    end
    in_if.tvalid = 1'b0;
    for (int j = 40; j < 48; j++) begin
      checks++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'(j)) begin
        errors++;
        $display("[TB] FAIL stream_tail%0d got v=%b d=%h want v=1 d=%h",
                 j, out_if.tvalid, out_if.tdata, 8'(j));
      end
      cycle();
    end
    checks++;
    if (out_if.tvalid !== 1'b0 || status_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL stream_empty got v=%b cnt=%0d want v=0 cnt=0",
               out_if.tvalid, status_count);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    out_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'h90 + 8'(i);
      in_if.tlast  = (i == 2);
      cycle();
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    checks++;
    if (status_count !== 5'd5 || status_frames !== 5'd1) begin
      errors++;
      $display("[TB] FAIL midrst_pre got cnt=%0d frm=%0d want cnt=5 frm=1",
               status_count, status_frames);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (status_count !== 5'd0 || out_if.tvalid !== 1'b0 || in_if.tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_async got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=0",
               status_count, out_if.tvalid, in_if.tready);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (in_if.tready !== 1'b1 || out_if.tvalid !== 1'b0 || out_if.tdata !== 8'h00 ||
        status_frames !== 5'd0) begin
      errors++;
      $display("[TB] FAIL midrst_release got rdy=%b v=%b d=%h frm=%0d want rdy=1 v=0 d=00 frm=0",
               in_if.tready, out_if.tvalid, out_if.tdata, status_frames);
    end
    in_if.tvalid = 1'b1;
    in_if.tdata  = 8'h5A;
    in_if.tlast  = 1'b1;
    cycle();
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    checks++;
    if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h5A || status_count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL midrst_fresh got v=%b d=%h cnt=%0d want v=1 d=5a cnt=1",
               out_if.tvalid, out_if.tdata, status_count);
    end
    out_if.tready = 1'b1;
    cycle();
    checks++;
    if (out_if.tvalid !== 1'b0 || status_count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL midrst_drain got v=%b cnt=%0d want v=0 cnt=0",
               out_if.tvalid, status_count);
    end
  endtask

`ifdef AXIS_OUT_FIFO_STORE_FWD_EN
  task automatic test_store_fwd();
    out_if.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.tvalid = 1'b1;
      in_if.tdata  = 8'hA0 + 8'(i);
      in_if.tlast  = (i == 2);
      cycle();
      checks++;
      if (out_if.tvalid !== 1'(i == 2)) begin
        errors++;
        $display("[TB] FAIL sf_valid%0d got %b want %b", i, out_if.tvalid, 1'(i == 2));
      end
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL sf_out%0d got v=%b d=%h want v=1 d=%h",
                 i, out_if.tvalid, out_if.tdata, 8'hA0 + 8'(i));
      end
      cycle();
    end
    checks++;
    if (out_if.tvalid !== 1'b0 || status_frames !== 5'd0) begin
      errors++;
      $display("[TB] FAIL sf_empty got v=%b frm=%0d want v=0 frm=0",
               out_if.tvalid, status_frames);
    end
  endtask

  task automatic test_store_fwd_oversize();
    int  in_idx;
    int  rd_idx;
    int  cyc;
    bit  released;
    in_idx   = 0;
    rd_idx   = 0;
    cyc      = 0;
    released = 0;
    out_if.tready = 1'b1;
    while ((rd_idx < 20) && (cyc < 300)) begin
      in_if.tvalid = (in_idx < 20);
      in_if.tdata  = 8'hC0 + 8'(in_idx);
      in_if.tlast  = (in_idx == 19);
      #1;
      if (out_if.tvalid === 1'b1) begin
        if (!released) begin
          released = 1;
          checks++;
          if (status_count !== 5'd16) begin
            errors++;
            $display("[TB] FAIL sf_release_count got %0d want 16", status_count);
          end
        end
        checks++;
        if (out_if.tdata !== 8'hC0 + 8'(rd_idx)) begin
          errors++;
          $display("[TB] FAIL sf_big%0d got %h want %h",
                   rd_idx, out_if.tdata, 8'hC0 + 8'(rd_idx));
        end
        rd_idx++;
      end
      if (in_if.tvalid && in_if.tready) begin
        in_idx++;
      end
      cycle();
      cyc++;
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    checks++;
    if (rd_idx != 20) begin
      errors++;
      $display("[TB] FAIL sf_big_timeout got %0d words want 20", rd_idx);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef AXIS_OUT_FIFO_STORE_FWD_EN
    test_store_fwd();
    test_store_fwd_oversize();
`else
    test_single_frame();
    test_fill();
    test_back_to_back();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
